// File: rtl/pid_regfile_pkg.sv
`default_nettype none
// ============================================================================
//  pid_regfile_pkg
//  Register map indices, status_i slice order and reset-value helper for the
//  PID register file.
//  Revision: 1.0
// ============================================================================
package pid_regfile_pkg;

    localparam int N_CFG = 9;
    localparam int N_ST  = 5;
    localparam int MAX_W = 64;

    typedef logic [3:0] reg_idx_t;

    localparam reg_idx_t REG_P         = 4'd0;
    localparam reg_idx_t REG_I         = 4'd1;
    localparam reg_idx_t REG_D         = 4'd2;
    localparam reg_idx_t REG_SP        = 4'd3;
    localparam reg_idx_t REG_OFF       = 4'd4;
    localparam reg_idx_t REG_I_UP      = 4'd5;
    localparam reg_idx_t REG_I_LOW     = 4'd6;
    localparam reg_idx_t REG_FLAGS     = 4'd7;
    localparam reg_idx_t REG_PID_O_VAL = 4'd8;
    localparam reg_idx_t REG_CMD       = 4'd9;
    localparam reg_idx_t REG_ERR       = 4'd10;
    localparam reg_idx_t REG_INTEGRAL  = 4'd11;
    localparam reg_idx_t REG_DERIV     = 4'd12;
    localparam reg_idx_t REG_SENS      = 4'd13;
    localparam reg_idx_t REG_PID_OUT   = 4'd14;
    localparam reg_idx_t REG_PWM_OUT   = 4'd15;

    // Slice order of each channel's field in status_i, low to high
    localparam int ST_ERR      = 0;
    localparam int ST_INTEGRAL = 1;
    localparam int ST_DERIV    = 2;
    localparam int ST_PID_OUT  = 3;
    localparam int ST_PWM_OUT  = 4;

    // Integrator limits reset to signed max/min of the data width (dw <= MAX_W)
    function automatic logic [MAX_W-1:0] cfg_rst_val(input int idx, input int dw);
        logic [MAX_W-1:0] v;
        v = '0;
        if (idx == int'(REG_I_UP)) begin
            v = {MAX_W{1'b1}} >> (MAX_W - dw + 1);
        end else if (idx == int'(REG_I_LOW)) begin
            v = {{(MAX_W-1){1'b0}}, 1'b1} << (dw - 1);
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pid_regfile_ch.sv
`default_nettype none
// ============================================================================
//  pid_regfile_ch
//  One PID channel bank: shadow/active config, status capture, commit logic.
//  Revision: 1.0
// ============================================================================
module pid_regfile_ch
    import pid_regfile_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SHADOW = 1
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic                    cfg_we_i,
    input  logic                    cmd_we_i,
    input  logic [3:0]              wr_idx_i,
    input  logic [DATA_W-1:0]       wr_data_i,
    input  logic                    sample_i,
    input  logic                    sens_rdy_i,
    input  logic [DATA_W-1:0]       sens_data_i,
    input  logic [N_ST*DATA_W-1:0]  status_i,
    input  logic [3:0]              rd_idx_i,
    output logic [DATA_W-1:0]       rd_data_o,
    output logic [N_CFG*DATA_W-1:0] cfg_o,
    output logic [DATA_W-1:0]       sens_o,
    output logic                    commit_pend_o
);

    logic [DATA_W-1:0] shadow_q [N_CFG];
    logic [DATA_W-1:0] shadow_d [N_CFG];
    logic [DATA_W-1:0] active_q [N_CFG];
    logic [DATA_W-1:0] active_d [N_CFG];
    logic [DATA_W-1:0] status_q [N_ST];
    logic [DATA_W-1:0] status_d [N_ST];
    logic [DATA_W-1:0] sens_q;
    logic [DATA_W-1:0] sens_d;
    logic              pend_q;
    logic              pend_d;
    logic              w_commit;

    function automatic logic [DATA_W-1:0] rst_of(input int k);
        return DATA_W'(cfg_rst_val(k, DATA_W));
    endfunction

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        pend_d   = 1'b0;
        w_commit = 1'b0;
        if (SHADOW != 0) begin
            // Commit copies the shadow as it stood before this cycle's write
            w_commit = sample_i && pend_q;
            for (int k = 0; k < N_CFG; k++) begin
                if (w_commit) begin
                    active_d[k] = shadow_q[k];
                end
                if (cfg_we_i && (wr_idx_i == 4'(k))) begin
                    shadow_d[k] = wr_data_i;
                end
            end
            pend_d = (pend_q && !w_commit) || (cmd_we_i && wr_data_i[0]);
        end else begin
            for (int k = 0; k < N_CFG; k++) begin
                if (cfg_we_i && (wr_idx_i == 4'(k))) begin
                    active_d[k] = wr_data_i;
                end
            end
        end
        for (int k = 0; k < N_ST; k++) begin
            status_d[k] = status_i[k*DATA_W +: DATA_W];
        end
        sens_d = sens_rdy_i ? sens_data_i : sens_q;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            for (int k = 0; k < N_CFG; k++) begin
                shadow_q[k] <= rst_of(k);
                active_q[k] <= rst_of(k);
            end
            for (int k = 0; k < N_ST; k++) begin
                status_q[k] <= '0;
            end
            sens_q <= '0;
            pend_q <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            status_q <= status_d;
            sens_q   <= sens_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < N_CFG; k++) begin
            if (rd_idx_i == 4'(k)) begin
                rd_data_o = (SHADOW != 0) ? shadow_q[k] : active_q[k];
            end
        end
        case (rd_idx_i)
            REG_ERR:      rd_data_o = status_q[ST_ERR];
            REG_INTEGRAL: rd_data_o = status_q[ST_INTEGRAL];
            REG_DERIV:    rd_data_o = status_q[ST_DERIV];
            REG_SENS:     rd_data_o = sens_q;
            REG_PID_OUT:  rd_data_o = status_q[ST_PID_OUT];
            REG_PWM_OUT:  rd_data_o = status_q[ST_PWM_OUT];
            default:      ;
        endcase
    end

    always_comb begin
        cfg_o = '0;
        for (int k = 0; k < N_CFG; k++) begin
            cfg_o[k*DATA_W +: DATA_W] = active_q[k];
        end
    end

    assign sens_o        = sens_q;
    assign commit_pend_o = pend_q;

endmodule
`default_nettype wire

// File: rtl/pid_regfile.sv
`default_nettype none
// ============================================================================
//  pid_regfile
//  Multi-channel PID register file: address decode, error flag and read mux.
//  Revision: 1.0
// ============================================================================
module pid_regfile
    import pid_regfile_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int N_CH   = 2,
    parameter  int SHADOW = 1,
    localparam int CH_W   = (N_CH <= 1) ? 1 : $clog2(N_CH),
    localparam int ADDR_W = CH_W + 4
) (
    input  logic                         clk_in,
    input  logic                         reset,
    input  logic                         wr_en_i,
    input  logic [ADDR_W-1:0]            wr_addr_i,
    input  logic [DATA_W-1:0]            wr_data_i,
    input  logic                         rd_en_i,
    input  logic [ADDR_W-1:0]            rd_addr_i,
    output logic [DATA_W-1:0]            rd_data_o,
    output logic                         rd_valid_o,
    output logic                         wr_err_o,
    input  logic [N_CH-1:0]              sample_i,
    input  logic [N_CH-1:0]              sens_rdy_i,
    input  logic [N_CH*DATA_W-1:0]       sens_data_i,
    input  logic [N_CH*N_ST*DATA_W-1:0]  status_i,
    output logic [N_CH*N_CFG*DATA_W-1:0] cfg_o,
    output logic [N_CH*DATA_W-1:0]       sens_o,
    output logic [N_CH-1:0]              commit_pend_o
);

    localparam int            C_N_BANK = 2 ** CH_W;
    localparam logic [CH_W:0] C_N_CH   = (CH_W + 1)'(N_CH);

    logic [CH_W-1:0]   w_wr_ch;
    logic [3:0]        w_wr_idx;
    logic [CH_W-1:0]   w_rd_ch;
    logic              w_wr_ch_ok;
    logic              w_cfg_we;
    logic              w_cmd_we;
    logic              w_wr_bad;
    logic [DATA_W-1:0] w_rd_bank [C_N_BANK];

    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;
    logic              rd_valid_q;
    logic              rd_valid_d;
    logic              wr_err_q;
    logic              wr_err_d;

    assign w_wr_ch    = wr_addr_i[ADDR_W-1:4];
    assign w_wr_idx   = wr_addr_i[3:0];
    assign w_rd_ch    = rd_addr_i[ADDR_W-1:4];
    assign w_wr_ch_ok = ({1'b0, w_wr_ch} < C_N_CH);

    // CMD writes are silently dropped without shadowing, never flagged
    assign w_cfg_we = wr_en_i && w_wr_ch_ok && (w_wr_idx < REG_CMD);
    assign w_cmd_we = wr_en_i && w_wr_ch_ok && (w_wr_idx == REG_CMD) && (SHADOW != 0);
    assign w_wr_bad = wr_en_i && (!w_wr_ch_ok || (w_wr_idx >= REG_ERR));

    for (genvar g = 0; g < C_N_BANK; g++) begin : g_ch
        if (g < N_CH) begin : g_bank
            pid_regfile_ch #(
                .DATA_W (DATA_W),
                .SHADOW (SHADOW)
            ) u_ch (
                .clk_in        (clk_in),
                .reset         (reset),
                .cfg_we_i      (w_cfg_we && (w_wr_ch == CH_W'(g))),
                .cmd_we_i      (w_cmd_we && (w_wr_ch == CH_W'(g))),
                .wr_idx_i      (w_wr_idx),
                .wr_data_i     (wr_data_i),
                .sample_i      (sample_i[g]),
                .sens_rdy_i    (sens_rdy_i[g]),
                .sens_data_i   (sens_data_i[g*DATA_W +: DATA_W]),
                .status_i      (status_i[g*N_ST*DATA_W +: N_ST*DATA_W]),
                .rd_idx_i      (rd_addr_i[3:0]),
                .rd_data_o     (w_rd_bank[g]),
                .cfg_o         (cfg_o[g*N_CFG*DATA_W +: N_CFG*DATA_W]),
                .sens_o        (sens_o[g*DATA_W +: DATA_W]),
                .commit_pend_o (commit_pend_o[g])
            );
        end else begin : g_empty
            assign w_rd_bank[g] = '0;
        end
    end

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_en_i;
        wr_err_d   = w_wr_bad;
        if (rd_en_i) begin
            rd_data_d = w_rd_bank[w_rd_ch];
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wr_err_q   <= wr_err_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign wr_err_o   = wr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pid_regfile.sv
`default_nettype none
// ============================================================================
//  tb_pid_regfile
//  Self-checking bench: directed table, corner sequences, random vs model.
//  Revision: 1.0
// ============================================================================
module tb_pid_regfile;

    localparam int DW  = 16;
    localparam int NCH = 2;
    localparam int AW  = 5;
    localparam int CW  = NCH * 9 * DW;

    logic              clk_in = 1'b0;
    logic              reset = 1'b1;
    logic              wr_en_i = 1'b0;
    logic [AW-1:0]     wr_addr_i = '0;
    logic [DW-1:0]     wr_data_i = '0;
    logic              rd_en_i = 1'b0;
    logic [AW-1:0]     rd_addr_i = '0;
    logic [DW-1:0]     rd_data_o;
    logic              rd_valid_o;
    logic              wr_err_o;
    logic [NCH-1:0]    sample_i = '0;
    logic [NCH-1:0]    sens_rdy_i = '0;
    logic [NCH*DW-1:0] sens_data_i = '0;
    logic [NCH*5*DW-1:0] status_i = '0;
    logic [CW-1:0]     cfg_o;
    logic [NCH*DW-1:0] sens_o;
    logic [NCH-1:0]    commit_pend_o;

    int errors = 0;
    int checks = 0;

    pid_regfile dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .wr_en_i       (wr_en_i),
        .wr_addr_i     (wr_addr_i),
        .wr_data_i     (wr_data_i),
        .rd_en_i       (rd_en_i),
        .rd_addr_i     (rd_addr_i),
        .rd_data_o     (rd_data_o),
        .rd_valid_o    (rd_valid_o),
        .wr_err_o      (wr_err_o),
        .sample_i      (sample_i),
        .sens_rdy_i    (sens_rdy_i),
        .sens_data_i   (sens_data_i),
        .status_i      (status_i),
        .cfg_o         (cfg_o),
        .sens_o        (sens_o),
        .commit_pend_o (commit_pend_o)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: register contents as plain arrays
    logic [DW-1:0] m_shadow [NCH][9];
    logic [DW-1:0] m_active [NCH][9];
    logic [DW-1:0] m_st     [NCH][5];
    logic [DW-1:0] m_sens   [NCH];
    logic          m_pend   [NCH];
    logic [DW-1:0] exp_rd = '0;
    logic          exp_rdv = 1'b0;
    logic          exp_err = 1'b0;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rst_val(input int k);
        if (k == 5) return 16'h7FFF;
        if (k == 6) return 16'h8000;
        return 16'h0000;
    endfunction

    task automatic m_reset();
        for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < 9; k++) begin
                m_shadow[c][k] = rst_val(k);
                m_active[c][k] = rst_val(k);
            end
            for (int k = 0; k < 5; k++) m_st[c][k] = '0;
            m_sens[c] = '0;
            m_pend[c] = 1'b0;
        end
        exp_rd  = '0;
        exp_rdv = 1'b0;
        exp_err = 1'b0;
    endtask

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        int c;
        int r;
        c = int'(a[4]);
        r = int'(a[3:0]);
        if (c >= NCH) return '0;
        if (r < 9) return m_shadow[c][r];
        case (r)
            10: return m_st[c][0];
            11: return m_st[c][1];
            12: return m_st[c][2];
            13: return m_sens[c];
            14: return m_st[c][3];
            15: return m_st[c][4];
            default: return '0;
        endcase
    endfunction

    // Advance one clock: update the model from the driven inputs, then compare
    task automatic tick();
        logic [CW-1:0]     e_cfg;
        logic [NCH*DW-1:0] e_sens;
        logic [NCH-1:0]    e_pend;
        int wc;
        int wi;
        if (reset) begin
            m_reset();
        end else begin
            wc = int'(wr_addr_i[4]);
            wi = int'(wr_addr_i[3:0]);
            exp_rdv = rd_en_i;
            if (rd_en_i) exp_rd = m_read(rd_addr_i);
            exp_err = wr_en_i && (wc >= NCH || wi >= 10);
            for (int c = 0; c < NCH; c++) begin
                logic commit;
                commit = sample_i[c] && m_pend[c];
                if (commit) begin
                    for (int k = 0; k < 9; k++) m_active[c][k] = m_shadow[c][k];
                end
                if (wr_en_i && wc == c && wi < 9) m_shadow[c][wi] = wr_data_i;
                m_pend[c] = (m_pend[c] && !commit) ||
                            (wr_en_i && wc == c && wi == 9 && wr_data_i[0]);
                for (int k = 0; k < 5; k++) m_st[c][k] = status_i[(c*5+k)*DW +: DW];
                if (sens_rdy_i[c]) m_sens[c] = sens_data_i[c*DW +: DW];
            end
        end
        @(posedge clk_in);
        #1;
        e_cfg = '0;
        e_sens = '0;
        for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < 9; k++) e_cfg[(c*9+k)*DW +: DW] = m_active[c][k];
            e_sens[c*DW +: DW] = m_sens[c];
            e_pend[c] = m_pend[c];
        end
        chk("rd_valid", CW'(rd_valid_o), CW'(exp_rdv));
        chk("rd_data", CW'(rd_data_o), CW'(exp_rd));
        chk("wr_err", CW'(wr_err_o), CW'(exp_err));
        chk("commit_pend", CW'(commit_pend_o), CW'(e_pend));
        chk("cfg_o", cfg_o, e_cfg);
        chk("sens_o", CW'(sens_o), CW'(e_sens));
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic re, input logic [AW-1:0] ra, input logic [NCH-1:0] smp);
        wr_en_i   = we;
        wr_addr_i = wa;
        wr_data_i = wd;
        rd_en_i   = re;
        rd_addr_i = ra;
        sample_i  = smp;
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          re;
        logic [AW-1:0] ra;
        logic [1:0]    smp;
        logic          e_rdv;
        logic [DW-1:0] e_rd;
        logic          e_err;
        logic [1:0]    e_pend;
        logic [DW-1:0] e_p1;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{1'b0, 5'h00, 16'h0000, 1'b1, 5'h05, 2'b00, 1'b1, 16'h7FFF, 1'b0, 2'b00, 16'h0000};
        tbl[1] = '{1'b0, 5'h00, 16'h0000, 1'b1, 5'h06, 2'b00, 1'b1, 16'h8000, 1'b0, 2'b00, 16'h0000};
        tbl[2] = '{1'b1, 5'h10, 16'h0123, 1'b0, 5'h00, 2'b00, 1'b0, 16'h8000, 1'b0, 2'b00, 16'h0000};
        tbl[3] = '{1'b1, 5'h19, 16'h0001, 1'b1, 5'h10, 2'b00, 1'b1, 16'h0123, 1'b0, 2'b10, 16'h0000};
        tbl[4] = '{1'b0, 5'h00, 16'h0000, 1'b0, 5'h00, 2'b10, 1'b0, 16'h0123, 1'b0, 2'b00, 16'h0123};
        tbl[5] = '{1'b1, 5'h0E, 16'hBEEF, 1'b0, 5'h00, 2'b00, 1'b0, 16'h0123, 1'b1, 2'b00, 16'h0123};
        tbl[6] = '{1'b0, 5'h00, 16'h0000, 1'b1, 5'h0E, 2'b00, 1'b1, 16'h1234, 1'b0, 2'b00, 16'h0123};
        tbl[7] = '{1'b0, 5'h00, 16'h0000, 1'b1, 5'h19, 2'b00, 1'b1, 16'h0000, 1'b0, 2'b00, 16'h0123};
        tbl[8] = '{1'b0, 5'h00, 16'h0000, 1'b1, 5'h0B, 2'b00, 1'b1, 16'h1111, 1'b0, 2'b00, 16'h0123};
        tbl[9] = '{1'b1, 5'h09, 16'h0002, 1'b1, 5'h09, 2'b00, 1'b1, 16'h0000, 1'b0, 2'b00, 16'h0123};

        status_i[1*DW +: DW] = 16'h1111;
        status_i[3*DW +: DW] = 16'h1234;
        status_i[7*DW +: DW] = 16'h5A5A;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra, tbl[i].smp);
            tick();
            chk("tbl_rd_valid", CW'(rd_valid_o), CW'(tbl[i].e_rdv));
            chk("tbl_rd_data", CW'(rd_data_o), CW'(tbl[i].e_rd));
            chk("tbl_wr_err", CW'(wr_err_o), CW'(tbl[i].e_err));
            chk("tbl_pend", CW'(commit_pend_o), CW'(tbl[i].e_pend));
            chk("tbl_cfg_ch1_p", CW'(cfg_o[9*DW +: DW]), CW'(tbl[i].e_p1));
        end

        // Sensor capture holds while ready is low
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        sens_rdy_i = 2'b01;
        sens_data_i = {16'h0000, 16'h0456};
        tick();
        sens_rdy_i = 2'b00;
        sens_data_i = {16'h0000, 16'h9999};
        tick();
        tick();
        chk("sens_hold", CW'(sens_o[DW-1:0]), CW'(16'h0456));
        drive(1'b0, '0, '0, 1'b1, 5'h0D, '0);
        tick();
        chk("sens_read", CW'(rd_data_o), CW'(16'h0456));

        // CMD coinciding with sample: commit waits for the next strobe
        drive(1'b1, 5'h00, 16'h0AAA, 1'b0, '0, '0);
        tick();
        drive(1'b1, 5'h09, 16'h0001, 1'b0, '0, 2'b01);
        tick();
        chk("cmd_smp_pend", CW'(commit_pend_o[0]), CW'(1'b1));
        chk("cmd_smp_nocommit", CW'(cfg_o[DW-1:0]), CW'(16'h0000));
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, 2'b01);
        tick();
        chk("second_smp_commit", CW'(cfg_o[DW-1:0]), CW'(16'h0AAA));
        chk("second_smp_pend", CW'(commit_pend_o[0]), CW'(1'b0));

        // Reset between the two strobes discards the pending commit
        drive(1'b1, 5'h00, 16'h0BBB, 1'b0, '0, '0);
        tick();
        drive(1'b1, 5'h09, 16'h0001, 1'b0, '0, 2'b01);
        tick();
        chk("pre_rst_pend", CW'(commit_pend_o[0]), CW'(1'b1));
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_pend", CW'(commit_pend_o[0]), CW'(1'b0));
        chk("rst_rd_valid", CW'(rd_valid_o), CW'(1'b0));
        drive(1'b0, '0, '0, 1'b1, 5'h00, 2'b01);
        tick();
        chk("rst_no_commit", CW'(cfg_o[DW-1:0]), CW'(16'h0000));
        chk("rst_shadow_p", CW'(rd_data_o), CW'(16'h0000));
        drive(1'b0, '0, '0, 1'b1, 5'h15, '0);
        tick();
        chk("rst_shadow_ch1_iup", CW'(rd_data_o), CW'(16'h7FFF));

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            reset      = ($urandom_range(0, 149) == 0);
            wr_en_i    = 1'($urandom);
            wr_addr_i  = AW'($urandom);
            if ($urandom_range(0, 3) == 0) wr_addr_i = {1'($urandom), 4'd9};
            wr_data_i  = DW'($urandom);
            rd_en_i    = 1'($urandom);
            rd_addr_i  = AW'($urandom);
            sample_i   = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            sens_rdy_i = NCH'($urandom);
            sens_data_i = {DW'($urandom), DW'($urandom)};
            for (int w = 0; w < NCH * 5; w++) status_i[w*DW +: DW] = DW'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
